// File: rtl/axil2wb_bridge_pkg.sv
// rtl/axil2wb_bridge_pkg.sv - shared response codes, FSM encoding and address helper for the AXI-Lite to Wishbone bridge
package axil2wb_bridge_pkg;

    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam logic [1:0]  RESP_SLVERR     = 2'b10;
    localparam logic [31:0] DEFAULT_WB_BASE = 32'h3000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB_WR  = 3'd1,
        ST_WB_RD  = 3'd2,
        ST_B_RESP = 3'd3,
        ST_R_RESP = 3'd4
    } state_t;

    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_t;

    // Wishbone sees word-aligned addresses with the window base merged in.
    function automatic logic [31:0] wb_word_addr(input logic [31:0] base, input logic [31:0] byte_addr);
        return base | (byte_addr & ~32'h3);
    endfunction

endpackage

// File: rtl/axil2wb_timeout.sv
// rtl/axil2wb_timeout.sv - loadable wait-cycle counter that flags expiry on the pLIMIT-th consecutive tick
module axil2wb_timeout #(
    parameter int pLIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic expire
);

    localparam int CW = (pLIMIT > 1) ? $clog2(pLIMIT + 1) : 1;

    logic [CW-1:0] count;

    // Expiry is qualified by tick, so a cycle without tick (e.g. an ack) never expires.
    assign expire = tick && (count == CW'(pLIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (tick && !expire) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/axil2wb_bridge.sv
// rtl/axil2wb_bridge.sv - AXI-Lite slave to Wishbone classic master, one outstanding single-beat transfer
module axil2wb_bridge
    import axil2wb_bridge_pkg::*;
#(
    parameter int          pDATA_WIDTH = 32,
    parameter int          pADDR_WIDTH = 12,
    parameter logic [31:0] pWB_BASE    = DEFAULT_WB_BASE,
    parameter int          pTIMEOUT    = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [pADDR_WIDTH-1:0]   awaddr,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [pDATA_WIDTH-1:0]   wdata,
    input  logic [pDATA_WIDTH/8-1:0] wstrb,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [pADDR_WIDTH-1:0]   araddr,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [pDATA_WIDTH-1:0]   rdata,
    output logic [1:0]               rresp,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [pDATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [31:0]              wbm_adr_o,
    output logic [pDATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [pDATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                     wbm_ack_i
);

    localparam int NB = pDATA_WIDTH / 8;

    state_t                 state, state_nxt;
    prio_t                  prio;
    logic                   aw_full, w_full, ar_full;
    logic [pADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [pDATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [NB-1:0]          wstrb_q;
    logic [1:0]             bresp_q, rresp_q;
    logic                   in_wb, wr_pend, rd_pend, contend, tmr_expire;
    logic                   aw_hs, w_hs, ar_hs, b_hs, r_hs;

    // Readies are held low during reset so nothing is accepted while the bridge is held.
    assign awready = (state == ST_IDLE) && !aw_full && !wb_rst_i;
    assign wready  = (state == ST_IDLE) && !w_full && !wb_rst_i;
    assign arready = (state == ST_IDLE) && !ar_full && !wb_rst_i
                     && !(aw_full && w_full && (prio == PRIO_WRITE));

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign b_hs    = (state == ST_B_RESP) && bready;
    assign r_hs    = (state == ST_R_RESP) && rready;

    assign in_wb   = (state == ST_WB_WR) || (state == ST_WB_RD);
    assign wr_pend = aw_full && w_full;
    assign rd_pend = ar_full;

    axil2wb_timeout #(
        .pLIMIT (pTIMEOUT)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .load   (state == ST_IDLE),
        .tick   (in_wb && !wbm_ack_i),
        .expire (tmr_expire)
    );

    always_comb begin
        state_nxt = state;
        contend   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_pend && rd_pend) begin
                    contend   = 1'b1;
                    state_nxt = (prio == PRIO_READ) ? ST_WB_RD : ST_WB_WR;
                end else if (wr_pend) begin
                    state_nxt = ST_WB_WR;
                end else if (rd_pend) begin
                    state_nxt = ST_WB_RD;
                end
            end
            ST_WB_WR:  if (wbm_ack_i || tmr_expire) state_nxt = ST_B_RESP;
            ST_WB_RD:  if (wbm_ack_i || tmr_expire) state_nxt = ST_R_RESP;
            ST_B_RESP: if (bready) state_nxt = ST_IDLE;
            ST_R_RESP: if (rready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            prio     <= PRIO_READ;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            ar_full  <= 1'b0;
            awaddr_q <= '0;
            araddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            // Only a contended choice moves priority; the loser of this round wins the next one.
            if (contend) prio <= (prio == PRIO_READ) ? PRIO_WRITE : PRIO_READ;

            if (aw_hs) begin
                aw_full  <= 1'b1;
                awaddr_q <= awaddr;
            end else if (b_hs) begin
                aw_full  <= 1'b0;
            end
            if (w_hs) begin
                w_full  <= 1'b1;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end else if (b_hs) begin
                w_full  <= 1'b0;
            end
            if (ar_hs) begin
                ar_full  <= 1'b1;
                araddr_q <= araddr;
            end else if (r_hs) begin
                ar_full  <= 1'b0;
            end

            if (state == ST_WB_WR) begin
                if (wbm_ack_i)       bresp_q <= RESP_OKAY;
                else if (tmr_expire) bresp_q <= RESP_SLVERR;
            end
            if (state == ST_WB_RD) begin
                if (wbm_ack_i) begin
                    rdata_q <= wbm_dat_i;
                    rresp_q <= RESP_OKAY;
                end else if (tmr_expire) begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
            end
        end
    end

    assign bvalid    = (state == ST_B_RESP);
    assign rvalid    = (state == ST_R_RESP);
    assign bresp     = bresp_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;

    assign wbm_cyc_o = in_wb;
    assign wbm_stb_o = in_wb;
    assign wbm_we_o  = (state == ST_WB_WR);
    assign wbm_adr_o = (state == ST_WB_WR) ? wb_word_addr(pWB_BASE, 32'(awaddr_q)) :
                       (state == ST_WB_RD) ? wb_word_addr(pWB_BASE, 32'(araddr_q)) : '0;
    assign wbm_sel_o = (state == ST_WB_WR) ? wstrb_q :
                       (state == ST_WB_RD) ? {NB{1'b1}} : '0;
    assign wbm_dat_o = (state == ST_WB_WR) ? wdata_q : '0;

endmodule

// File: tb/tb_axil2wb_bridge.sv
// tb/tb_axil2wb_bridge.sv - directed and randomized bench for axil2wb_bridge with a memory-backed reference model
module tb_axil2wb_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    always #5 clk = ~clk;

    axil2wb_bridge #(
        .pTIMEOUT (TMO)
    ) dut (
        .wb_clk_i  (clk),       .wb_rst_i  (rst),
        .awvalid   (awvalid),   .awready   (awready),   .awaddr (awaddr),
        .wvalid    (wvalid),    .wready    (wready),    .wdata  (wdata),  .wstrb (wstrb),
        .bvalid    (bvalid),    .bready    (bready),    .bresp  (bresp),
        .arvalid   (arvalid),   .arready   (arready),   .araddr (araddr),
        .rvalid    (rvalid),    .rready    (rready),    .rdata  (rdata),  .rresp (rresp),
        .wbm_cyc_o (wbm_cyc_o), .wbm_stb_o (wbm_stb_o), .wbm_we_o (wbm_we_o),
        .wbm_sel_o (wbm_sel_o), .wbm_adr_o (wbm_adr_o), .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i), .wbm_ack_i (wbm_ack_i)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          slv_wait;
    bit          stray_ack;
    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] obs_adr, obs_dat;
    logic [3:0]  obs_sel;
    logic        obs_we;
    int          cyc_len;
    bit          unstable;
    bit          in_cyc;
    int          wcnt;
    bit          we_log [$];
    bit          model_prio;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Wishbone slave: acks after slv_wait wait states, applies writes to its own memory.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        in_cyc    = 1'b0;
        wcnt      = 0;
        forever begin
            @(posedge clk); #1;
            wbm_ack_i = stray_ack;
            wbm_dat_i = $urandom;
            if (wbm_cyc_o && wbm_stb_o) begin
                if (!in_cyc) begin
                    in_cyc  = 1'b1;
                    wcnt    = 0;
                    obs_adr = wbm_adr_o;
                    obs_sel = wbm_sel_o;
                    obs_we  = wbm_we_o;
                    obs_dat = wbm_dat_o;
                    we_log.push_back(wbm_we_o);
                end else if (wbm_adr_o !== obs_adr || wbm_sel_o !== obs_sel ||
                             wbm_we_o !== obs_we || wbm_dat_o !== obs_dat) begin
                    unstable = 1'b1;
                end
                cyc_len   = wcnt + 1;
                wbm_ack_i = (wcnt == slv_wait);
                if (wcnt == slv_wait) begin
                    if (wbm_we_o) slv_mem[wbm_adr_o[5:2]] = merge(slv_mem[wbm_adr_o[5:2]], wbm_dat_o, wbm_sel_o);
                    else          wbm_dat_i = slv_mem[wbm_adr_o[5:2]];
                end
                wcnt++;
            end else begin
                in_cyc = 1'b0;
            end
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int wdly, input int bdly,
                             output logic [1:0] resp, output int lat, output bit early);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = (wdly == 0);
        aw_done = 0; w_done = 0; n = 0; early = 0;
        while (!(aw_done && w_done) && n < 100) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            if (wbm_cyc_o && !w_done) early = 1;
            @(posedge clk); #1;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin wvalid = 1'b0;  w_done = 1;  end
            n++;
            if (!w_done && n >= wdly) wvalid = 1'b1;
        end
        check("aw_w_capture_bound", 32'(aw_done && w_done), 1);
        lat = 0; n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bvalid) break;
            lat++; n++;
        end
        check("bvalid_bound", 32'(bvalid), 1);
        resp = bresp;
        for (int k = 0; k < bdly; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", 32'({bvalid, awready, arready}), 32'h4);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", 32'(bvalid), 0);
    endtask

    task automatic axi_read(input logic [11:0] a, input int rdly,
                            output logic [1:0] resp, output logic [31:0] data, output int lat);
        bit done, hs;
        int n;
        araddr = a; arvalid = 1'b1; done = 0; n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) begin arvalid = 1'b0; done = 1; end
            n++;
        end
        check("ar_capture_bound", 32'(done), 1);
        lat = 0; n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (rvalid) break;
            lat++; n++;
        end
        check("rvalid_bound", 32'(rvalid), 1);
        resp = rresp;
        data = rdata;
        for (int k = 0; k < rdly; k++) begin
            @(posedge clk); #1;
            check("rvalid_hold", 32'({rvalid, arready, awready}), 32'h4);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", 32'(rvalid), 0);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int wdly, input int bdly, input int wt);
        logic [1:0] resp;
        int lat;
        bit early, ok;
        slv_wait = wt; unstable = 0; cyc_len = 0; obs_adr = '1;
        axi_write(a, d, s, wdly, bdly, resp, lat, early);
        ok = (wt < TMO);
        check("wr_bresp",   32'(resp), ok ? 0 : 2);
        check("wr_latency", 32'(lat), 1 + (ok ? wt + 1 : TMO));
        check("wr_cyc_len", 32'(cyc_len), ok ? wt + 1 : TMO);
        check("wr_adr",     obs_adr, 32'h3000_0000 | 32'({a[11:2], 2'b00}));
        check("wr_sel_we",  32'({obs_sel, obs_we}), 32'({s, 1'b1}));
        check("wr_dat",     obs_dat, d);
        check("wr_stable",  32'(unstable), 0);
        check("wr_early",   32'(early), 0);
        if (ok) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
    endtask

    task automatic do_read(input logic [11:0] a, input int rdly, input int wt);
        logic [1:0]  resp;
        logic [31:0] data;
        int lat;
        bit ok;
        slv_wait = wt; unstable = 0; cyc_len = 0; obs_adr = '1;
        axi_read(a, rdly, resp, data, lat);
        ok = (wt < TMO);
        check("rd_rresp",   32'(resp), ok ? 0 : 2);
        check("rd_rdata",   data, ok ? ref_mem[a[5:2]] : 0);
        check("rd_latency", 32'(lat), 1 + (ok ? wt + 1 : TMO));
        check("rd_cyc_len", 32'(cyc_len), ok ? wt + 1 : TMO);
        check("rd_adr",     obs_adr, 32'h3000_0000 | 32'({a[11:2], 2'b00}));
        check("rd_sel_we",  32'({obs_sel, obs_we}), 32'h1E);
        check("rd_stable",  32'(unstable), 0);
    endtask

    // Write and read to the same word become ready together; the serve order shows in the read data.
    task automatic do_contend(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] exp_rd, got_rd;
        logic [1:0]  got_br, got_rr;
        bit rd_first, aw_done, w_done, ar_done, hs_aw, hs_w, hs_ar, got_b, got_r;
        int n;
        slv_wait = 0;
        we_log.delete();
        rd_first   = (model_prio == 0);
        model_prio = !model_prio;
        if (rd_first) begin
            exp_rd = ref_mem[a[5:2]];
            ref_mem[a[5:2]] = d;
        end else begin
            ref_mem[a[5:2]] = d;
            exp_rd = d;
        end
        awaddr = a; araddr = a; wdata = d; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        aw_done = 0; w_done = 0; ar_done = 0; n = 0;
        while (!(aw_done && w_done && ar_done) && n < 100) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_ar = arvalid && arready;
            @(posedge clk); #1;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin wvalid = 1'b0;  w_done = 1;  end
            if (hs_ar) begin arvalid = 1'b0; ar_done = 1; end
            n++;
        end
        check("ct_capture_bound", 32'(aw_done && w_done && ar_done), 1);
        bready = 1'b1; rready = 1'b1;
        got_b = 0; got_r = 0; n = 0;
        got_br = 2'b11; got_rr = 2'b11; got_rd = '1;
        while (!(got_b && got_r) && n < 100) begin
            @(negedge clk);
            if (bvalid) begin got_b = 1; got_br = bresp; end
            if (rvalid) begin got_r = 1; got_rr = rresp; got_rd = rdata; end
            n++;
        end
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        check("ct_resp_bound", 32'(got_b && got_r), 1);
        check("ct_resps",      32'({got_br, got_rr}), 0);
        check("ct_rdata",      got_rd, exp_rd);
        check("ct_wb_count",   32'(we_log.size()), 2);
        check("ct_first_is_wr", 32'(we_log[0]), 32'(!rd_first));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] a;
        int n;
        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        slv_wait = 0; stray_ack = 0; model_prio = 0;
        for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end
        slv_mem[9] = 32'h1234_5678;
        ref_mem[9] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({awready, wready, arready, bvalid, rvalid, wbm_cyc_o, wbm_stb_o, wbm_we_o}), 0);
        check("rst_adr",  wbm_adr_o, 0);
        check("rst_misc", 32'({bresp, rresp, wbm_sel_o}), 0);
        check("rst_data", rdata | wbm_dat_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'({awready, wready, arready}), 32'h7);

        do_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("wr1_adr_abs", obs_adr, 32'h3000_0010);
        do_read(12'h024, 0, 3);
        check("rd1_cyc4", 32'(cyc_len), 4);
        do_write(12'h014, 32'hA5A5_C3C3, 4'b0011, 5, 0, 1);
        check("wr_late_w_sel", 32'(obs_sel), 32'h3);
        do_read(12'h014, 0, 0);
        do_write(12'h010, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        do_read(12'h010, 0, 0);
        do_read(12'h024, 0, 8);
        do_read(12'h024, 0, 7);
        do_write(12'h018, 32'h0BAD_F00D, 4'hF, 0, 0, 8);
        do_read(12'h018, 0, 0);
        do_write(12'h01C, 32'h5555_AAAA, 4'hF, 0, 10, 0);
        do_read(12'h01C, 4, 2);

        stray_ack = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("stray_ignored", 32'({wbm_cyc_o, bvalid, rvalid}), 0);
        end
        do_write(12'h020, 32'h1357_9BDF, 4'hF, 0, 0, 3);
        stray_ack = 0;

        do_contend(12'h030, 32'hC0DE_0001);
        do_contend(12'h030, 32'hC0DE_0002);

        for (int i = 0; i < 40; i++) begin
            a = 12'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 9));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 9));
        end

        do_contend(12'h034, 32'hC0DE_0003);

        slv_wait = 20;
        araddr = 12'h040; arvalid = 1'b1; n = 0;
        while (!wbm_cyc_o && n < 20) begin
            @(negedge clk);
            if (arvalid && arready) begin
                @(posedge clk); #1;
                arvalid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        check("rst_mid_started", 32'(wbm_cyc_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_drop", 32'({wbm_cyc_o, wbm_stb_o, rvalid}), 0);
        @(negedge clk);
        rst = 1'b0;
        model_prio = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_resp", 32'({wbm_cyc_o, rvalid, bvalid}), 0);
        check("rst_mid_ready",   32'({awready, wready, arready}), 32'h7);

        do_contend(12'h038, 32'hC0DE_0004);
        do_read(12'h038, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axil2wb_bridge.md
Name: axil2wb_bridge

Overview:
- AXI-Lite slave to Wishbone classic master bridge; the reverse direction of the existing Wishbone-to-AXI bridge.
- Lets an AXI-Lite initiator (e.g. a user DMA/FIR controller) issue single-beat reads/writes onto the Caravel-side Wishbone bus.
- One outstanding transaction at a time; a timeout returns SLVERR if no Wishbone ack arrives.

Parameters:
pDATA_WIDTH, 32, AXI/WB data width (fixed 32; byte lanes = 4)
pADDR_WIDTH, 12, AXI-Lite address width
pWB_BASE, 32'h3000_0000, base OR'd onto the AXI address to form wbm_adr_o
pTIMEOUT, 255, max cycles to wait for wbm_ack_i before error (counter width = clog2(pTIMEOUT+1))

Ports:
wb_clk_i  in  1  single clock for AXI and WB sides
wb_rst_i  in  1  asynchronous active-high reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  pADDR_WIDTH  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data
wstrb  in  4  write byte strobes
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  00 OKAY, 10 SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  pADDR_WIDTH  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
wbm_cyc_o  out  1  WB cycle
wbm_stb_o  out  1  WB strobe
wbm_we_o  out  1  WB write enable
wbm_sel_o  out  4  WB byte selects
wbm_adr_o  out  32  WB address
wbm_dat_o  out  32  WB write data
wbm_dat_i  in  32  WB read data
wbm_ack_i  in  1  WB acknowledge

Behaviour:
- Reset: one clock (wb_clk_i); reset is asynchronous and active-high (wb_rst_i). All outputs 0, FSM to IDLE, latches cleared, arbitration priority = read. Reset mid-cycle drops cyc/stb immediately; no response is issued for the aborted transaction.
- AW and W are captured independently into holding regs (aw_full, w_full). awready = !aw_full && state==IDLE; wready = !w_full && state==IDLE. A handshake occurs on valid&&ready in the same cycle; both may complete in one cycle.
- arready = (state==IDLE) && !(aw_full && w_full && prio==WRITE). Read address is latched on handshake.
- FSM states: IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
- IDLE: write is ready when aw_full&&w_full; read is ready when ar latched. If both are ready, alternate priority: the last-served type loses. Go to WB_WR or WB_RD next cycle.
- WB_WR/WB_RD: cyc=stb=1; we=1 for write. adr = pWB_BASE | {awaddr/araddr[pADDR_WIDTH-1:2],2'b00}. sel = wstrb for write, 4'hF for read; dat_o = wdata. Hold stable until wbm_ack_i.
- On ack: drop cyc/stb the same edge. Read captures rdata=wbm_dat_i with rresp=00 and goes to R_RESP. Write sets bresp=00 and goes to B_RESP. Minimum latency from address/data capture to bvalid/rvalid: 2 cycles with zero-wait ack.
- Timeout: counter resets on entering WB_*, increments each cycle without ack. At count==pTIMEOUT, drop cyc/stb and respond 10 (SLVERR); rdata=0 for reads. An ack arriving in the same cycle as expiry wins (OKAY).
- wstrb==0: still performs a WB cycle with sel=0; response OKAY.
- B_RESP: bvalid=1 until bready; then clear aw_full/w_full and bvalid, and go to IDLE. R_RESP: same with rvalid/rready.
- Stray wbm_ack_i outside WB_* states is ignored.

Decomposition:
- Shared package: AXI response codes (RESP_OKAY=2'b00, RESP_SLVERR=2'b10), FSM state encoding, default base address constant.
- One natural sub-module: axil2wb_timeout (loadable cycle counter with expire flag), reusable by the wb2axi bridge.

Test Plan:
- Write: awaddr=12'h010, wdata=32'hDEADBEEF, wstrb=4'hF with same-cycle AW/W, ack after 1 cycle -> wbm_adr_o=32'h3000_0010, we=1, sel=F; bvalid with bresp=00 two cycles after capture.
- Read: araddr=12'h024, slave returns 32'h1234_5678 after 3 wait cycles -> rdata=32'h1234_5678, rresp=00; cyc held 4 cycles.
- AW first, W 5 cycles later with wstrb=4'b0011 -> no WB cycle until W is captured; then sel=0011.
- Simultaneous ready read+write from reset -> read served first, then write; next contention serves write first.
- No ack, pTIMEOUT=8 -> cyc drops after 8 cycles; rresp=10 and rdata=0.
- bready held low 10 cycles -> bvalid stays 1, awready/arready stay 0. Asserting wb_rst_i during WB_RD -> cyc/stb/rvalid go 0 immediately.
